// File: rtl/zesal_arrays_if.sv
// Command/response bundle for the zesal_arrays engine: sequencer side is master,
// engine side is slave.
interface zesal_arrays_if #(
  parameter int ARRAYS  = 4,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int OP_BITS = 5
);
  localparam int A_BITS = $clog2(ARRAYS);
  localparam int I_BITS = $clog2(DEPTH);

  logic               in_valid;
  logic               in_ready;
  logic [OP_BITS-1:0] in_op;
  logic [A_BITS-1:0]  in_array;
  logic [I_BITS-1:0]  in_index;
  logic [WIDTH-1:0]   in_data;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_status;

  modport master (
    output in_valid, in_op, in_array, in_index, in_data,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_op, in_array, in_index, in_data,
    output in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/zesal_arrays.sv
// Multi-array command engine: ARRAYS arrays of DEPTH x WIDTH with live size and
// allocation flag; one command per IDLE -> EXEC -> RESP pass.
module zesal_arrays #(
  parameter int ARRAYS  = 4,
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int OP_BITS = 5
) (
  input  logic          clock,
  input  logic          reset,
  zesal_arrays_if.slave bus
);
  localparam int A_BITS = $clog2(ARRAYS);
  localparam int I_BITS = $clog2(DEPTH);
  localparam int S_BITS = I_BITS + 1;
  localparam logic [S_BITS-1:0] FULL_SZ = S_BITS'(DEPTH);

  localparam logic [OP_BITS-1:0] OP_RESET = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_WRITE = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_READ  = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_SIZE  = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_INC   = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_DEC   = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_PUSH  = OP_BITS'(14);
  localparam logic [OP_BITS-1:0] OP_POP   = OP_BITS'(15);
  localparam logic [OP_BITS-1:0] OP_ALLOC = OP_BITS'(18);
  localparam logic [OP_BITS-1:0] OP_FREE  = OP_BITS'(19);
  localparam logic [OP_BITS-1:0] OP_ADD   = OP_BITS'(20);
  localparam logic [OP_BITS-1:0] OP_SUB   = OP_BITS'(22);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_RANGE = 2'd2;
  localparam logic [1:0] ST_BAD   = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [OP_BITS-1:0] op;
    logic [A_BITS-1:0]  arr;
    logic [I_BITS-1:0]  idx;
    logic [WIDTH-1:0]   data;
  } cmd_t;

  typedef struct packed {
    logic              wr;
    logic [A_BITS-1:0] tgt;
    logic [I_BITS-1:0] widx;
    logic [WIDTH-1:0]  wval;
    logic              sz_en;
    logic [S_BITS-1:0] sz_val;
    logic              al_en;
    logic              al_val;
    logic              clr;
    logic [WIDTH-1:0]  data;
    logic [1:0]        status;
  } res_t;

  state_t                         state;
  cmd_t                           cmd;
  res_t                           res, nxt;
  logic [WIDTH-1:0]               mem [ARRAYS][DEPTH];
  logic [ARRAYS-1:0][S_BITS-1:0]  size_q;
  logic [ARRAYS-1:0]              alloc_q;
  logic                           in_ready_q, out_valid_q;
  logic [WIDTH-1:0]               out_data_q;
  logic [1:0]                     out_status_q;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_status = out_status_q;

  logic [S_BITS-1:0] sz;
  logic [I_BITS-1:0] top_idx;
  logic [WIDTH-1:0]  elem, top;
  logic              in_rng, not_full, non_empty;

  assign sz        = size_q[cmd.arr];
  // low bits of size-1 also give DEPTH-1 when the array is full
  assign top_idx   = sz[I_BITS-1:0] - 1'b1;
  assign elem      = mem[cmd.arr][cmd.idx];
  assign top       = mem[cmd.arr][top_idx];
  assign in_rng    = {1'b0, cmd.idx} < sz;
  assign not_full  = sz < FULL_SZ;
  assign non_empty = sz != '0;

  logic              free_any;
  logic [A_BITS-1:0] free_idx;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ARRAYS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_any = 1'b1;
        free_idx = A_BITS'(i);
      end
    end
  end

  always_comb begin
    nxt        = '0;
    nxt.tgt    = cmd.arr;
    nxt.widx   = cmd.idx;
    nxt.status = ST_OK;
    case (cmd.op)
      OP_RESET: nxt.clr = 1'b1;
      OP_ALLOC: begin
        if (free_any) begin
          nxt.tgt    = free_idx;
          nxt.al_en  = 1'b1;
          nxt.al_val = 1'b1;
          nxt.sz_en  = 1'b1;
          nxt.data   = WIDTH'(free_idx);
        end else nxt.status = ST_FULL;
      end
      OP_WRITE, OP_READ, OP_SIZE, OP_INC, OP_DEC, OP_PUSH, OP_POP,
      OP_FREE, OP_ADD, OP_SUB: begin
        if (!alloc_q[cmd.arr]) nxt.status = ST_BAD;
        else begin
          case (cmd.op)
            OP_WRITE: if (in_rng) begin
              nxt.wr = 1'b1; nxt.wval = cmd.data; nxt.data = cmd.data;
            end else nxt.status = ST_RANGE;
            OP_READ: if (in_rng) nxt.data = elem;
                     else nxt.status = ST_RANGE;
            OP_SIZE: nxt.data = WIDTH'(sz);
            OP_INC: if (not_full) begin
              nxt.sz_en = 1'b1; nxt.sz_val = sz + 1'b1; nxt.data = WIDTH'(sz + 1'b1);
            end else begin
              nxt.status = ST_FULL; nxt.data = WIDTH'(FULL_SZ);
            end
            OP_DEC: if (non_empty) begin
              nxt.sz_en = 1'b1; nxt.sz_val = sz - 1'b1; nxt.data = WIDTH'(sz - 1'b1);
            end else nxt.status = ST_RANGE;
            OP_PUSH: if (not_full) begin
              nxt.wr = 1'b1; nxt.widx = sz[I_BITS-1:0]; nxt.wval = cmd.data;
              nxt.sz_en = 1'b1; nxt.sz_val = sz + 1'b1; nxt.data = cmd.data;
            end else nxt.status = ST_FULL;
            OP_POP: if (non_empty) begin
              nxt.sz_en = 1'b1; nxt.sz_val = sz - 1'b1; nxt.data = top;
            end else nxt.status = ST_RANGE;
            OP_FREE: begin
              nxt.al_en = 1'b1; nxt.sz_en = 1'b1;
            end
            OP_ADD: if (in_rng) begin
              nxt.wr = 1'b1; nxt.wval = elem + cmd.data; nxt.data = elem + cmd.data;
            end else nxt.status = ST_RANGE;
            OP_SUB: if (in_rng) begin
              nxt.wr = 1'b1; nxt.wval = elem - cmd.data; nxt.data = elem - cmd.data;
            end else nxt.status = ST_RANGE;
            default: nxt.status = ST_BAD;
          endcase
        end
      end
      default: nxt.status = ST_BAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= ST_OK;
      size_q       <= '0;
      alloc_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.in_valid && in_ready_q) begin
          cmd        <= '{op: bus.in_op, arr: bus.in_array, idx: bus.in_index, data: bus.in_data};
          in_ready_q <= 1'b0;
          state      <= EXEC;
        end
        EXEC: begin
          res   <= nxt;
          state <= RESP;
        end
        RESP: begin
          if (res.clr) begin
            size_q  <= '0;
            alloc_q <= '0;
          end else begin
            if (res.sz_en) size_q[res.tgt]  <= res.sz_val;
            if (res.al_en) alloc_q[res.tgt] <= res.al_val;
          end
          out_valid_q  <= 1'b1;
          out_data_q   <= res.data;
          out_status_q <= res.status;
          in_ready_q   <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // element storage survives reset; a reset during EXEC never reaches RESP
  always_ff @(posedge clock) begin
    if (reset && state == RESP && res.wr) mem[res.tgt][res.widx] <= res.wval;
  end
endmodule

// File: tb/tb_zesal_arrays.sv
// Directed bench for zesal_arrays: expected results queued at issue, compared
// by a response monitor.
module tb_zesal_arrays;
  localparam int ARRAYS = 4, DEPTH = 16, WIDTH = 8, OP_BITS = 5;
  localparam int OK = 0, FULL = 1, RANGE = 2, BAD = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  zesal_arrays_if #(.ARRAYS(ARRAYS), .DEPTH(DEPTH), .WIDTH(WIDTH), .OP_BITS(OP_BITS)) bus ();
  zesal_arrays #(.ARRAYS(ARRAYS), .DEPTH(DEPTH), .WIDTH(WIDTH), .OP_BITS(OP_BITS))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [WIDTH+1:0] exp_q[$];
  string            tag_q[$];
  logic [WIDTH+1:0] m_exp;
  string            m_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 32'(bus.out_valid), 32'd0);
      else begin
        m_exp = exp_q.pop_front();
        m_tag = tag_q.pop_front();
        chk({m_tag, "_data"}, 32'(bus.out_data), 32'(m_exp[WIDTH+1:2]));
        chk({m_tag, "_status"}, 32'(bus.out_status), 32'(m_exp[1:0]));
      end
    end
  end

  task automatic drive(input int op, input int arr, input int idx, input int data);
    int n;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_BITS'(op);
    bus.in_array = 2'(arr);
    bus.in_index = 4'(idx);
    bus.in_data  = WIDTH'(data);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (bus.in_ready !== 1'b1) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input int op, input int arr, input int idx,
                      input int data, input int ed, input int es);
    int n;
    exp_q.push_back({WIDTH'(ed), 2'(es)});
    tag_q.push_back(tag);
    drive(op, arr, idx, data);
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_array = '0;
    bus.in_index = '0;
    bus.in_data  = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_status", 32'(bus.out_status), 32'd0);

    send("size_unalloc", 4, 0, 0, 0, 0, BAD);
    for (int i = 0; i < ARRAYS; i++) send("alloc", 18, 0, 0, 0, i, OK);
    send("alloc_full", 18, 0, 0, 0, 0, FULL);
    send("free2", 19, 2, 0, 0, 0, OK);
    send("realloc2", 18, 0, 0, 0, 2, OK);

    send("push11", 14, 0, 0, 8'h11, 8'h11, OK);
    send("push22", 14, 0, 0, 8'h22, 8'h22, OK);
    send("push33", 14, 0, 0, 8'h33, 8'h33, OK);
    send("size3", 4, 0, 0, 0, 3, OK);
    send("pop33", 15, 0, 0, 0, 8'h33, OK);
    send("pop22", 15, 0, 0, 0, 8'h22, OK);
    send("size1", 4, 0, 0, 0, 1, OK);

    for (int i = 0; i < DEPTH; i++) send("fill", 14, 1, 0, 8'h40 + i, 8'h40 + i, OK);
    send("push_full", 14, 1, 0, 8'h99, 0, FULL);
    send("size_depth", 4, 1, 0, 0, DEPTH, OK);
    for (int i = DEPTH - 1; i >= 0; i--) send("drain", 15, 1, 0, 0, 8'h40 + i, OK);
    send("pop_empty", 15, 1, 0, 0, 0, RANGE);

    for (int i = 1; i <= DEPTH; i++) send("inc", 5, 1, 0, 0, i, OK);
    send("inc_full", 5, 1, 0, 0, DEPTH, FULL);
    send("dec_empty", 6, 3, 0, 0, 0, RANGE);
    send("inc3", 5, 3, 0, 0, 1, OK);
    send("dec3", 6, 3, 0, 0, 0, OK);

    send("write_f0", 2, 0, 0, 8'hF0, 8'hF0, OK);
    send("add_wrap", 20, 0, 0, 8'h20, 8'h10, OK);
    send("sub_wrap", 22, 0, 0, 8'h11, 8'hFF, OK);
    send("read_range", 3, 0, 5, 0, 0, RANGE);
    send("read0", 3, 0, 0, 0, 8'hFF, OK);
    send("write_range", 2, 0, 1, 8'h55, 0, RANGE);
    send("free3", 19, 3, 0, 0, 0, OK);
    send("read_freed", 3, 3, 0, 0, 0, BAD);

    // opcode 9: cycle-exact response timing
    exp_q.push_back({WIDTH'(0), 2'(BAD)});
    tag_q.push_back("op9");
    drive(9, 0, 0, 0);
    @(negedge clock);
    chk("op9_v_n1", 32'(bus.out_valid), 32'd0);
    chk("op9_rdy_n1", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    chk("op9_v_n2", 32'(bus.out_valid), 32'd0);
    chk("op9_rdy_n2", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    chk("op9_v_n3", 32'(bus.out_valid), 32'd1);
    @(negedge clock);
    chk("op9_v_n4", 32'(bus.out_valid), 32'd0);

    // reset lands while a Push is in EXEC: no response, no commit
    drive(14, 0, 0, 8'h77);
    reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_status", 32'(bus.out_status), 32'd0);
    repeat (4) @(negedge clock);
    send("size_after_rst", 4, 0, 0, 0, 0, BAD);
    send("alloc_after_rst", 18, 0, 0, 0, 0, OK);
    send("size0_after_rst", 4, 0, 0, 0, 0, OK);
    send("read_after_rst", 3, 0, 0, 0, 0, RANGE);
    send("reset_cmd", 1, 0, 0, 0, 0, OK);
    send("size_after_cmd", 4, 0, 0, 0, 0, BAD);

    repeat (5) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
